// File: rtl/autosym_eval.sv
// autosym_eval: two-stage pipelined evaluator of f(x) = TT[z], z[i] = ^(x & ROW[i]), with CFG/RUN/DRAIN control.
// Optional macro AUTOSYM_CNT_EN adds ones_cnt, a saturating count of delivered y=1 results.
module autosym_eval #(
  parameter int N_IN = 8,
  parameter int K = 4,
  localparam int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_row_we,
  input  logic [AW-1:0]   cfg_row_addr,
  input  logic [N_IN-1:0] cfg_row_data,
  input  logic            cfg_tt_we,
  input  logic [K-1:0]    cfg_tt_addr,
  input  logic            cfg_tt_bit,
  input  logic            cfg_lock,
  input  logic            cfg_unlock,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            y,
  output logic            running
`ifdef AUTOSYM_CNT_EN
  ,
  output logic [15:0]     ones_cnt
`endif
);
  typedef enum logic [1:0] {CFG, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [N_IN-1:0] r_row [K];
  logic [2**K-1:0] r_tt;
  logic [K-1:0] r_z, w_z;
  logic r_v1, r_v2, r_y, w_adv2, w_acc;
  always_ff @(posedge clk)
    if (rst) r_state <= CFG;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == CFG && cfg_lock) ? RUN :
             (r_state == RUN && cfg_unlock) ? DRAIN :
             (r_state == DRAIN && !r_v1 && !r_v2) ? CFG : r_state;
    w_adv2 = !r_v2 || out_ready;
    in_ready = (r_state == RUN) && (!r_v1 || w_adv2);
    w_acc = in_valid && in_ready;
    running = r_state == RUN;
    out_valid = r_v2;
    y = r_y;
    w_z = '0;
    for (int i = 0; i < K; i++) w_z[i] = ^(x & r_row[i]);
  end
  // Configuration is frozen outside CFG so DRAIN finishes with the captured table.
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < K; i++) r_row[i] <= '0;
      r_tt <= '0;
    end else if (r_state == CFG) begin
      if (cfg_row_we) r_row[cfg_row_addr] <= cfg_row_data;
      if (cfg_tt_we) r_tt[cfg_tt_addr] <= cfg_tt_bit;
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_z <= '0;
      r_y <= 1'b0;
    end else begin
      if (w_adv2 || !r_v1) begin
        r_v1 <= w_acc;
        if (w_acc) r_z <= w_z;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) r_y <= r_tt[r_z];
      end
    end
`ifdef AUTOSYM_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || (r_state == CFG && cfg_lock)) r_cnt <= '0;
    else if (r_v2 && out_ready && r_y && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign ones_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_autosym_eval.sv
// tb_autosym_eval: directed, table-driven bench for autosym_eval (N_IN=8, K=4).
module tb_autosym_eval;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_row_we = 1'b0, cfg_tt_we = 1'b0, cfg_tt_bit = 1'b0, cfg_lock = 1'b0, cfg_unlock = 1'b0;
  logic [1:0] cfg_row_addr = '0;
  logic [7:0] cfg_row_data = '0, x = '0;
  logic [3:0] cfg_tt_addr = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, y, running;
`ifdef AUTOSYM_CNT_EN
  logic [15:0] ones_cnt;
`endif
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] x; logic y;} vec_t;
  vec_t vt[10];

  autosym_eval #(.N_IN(8), .K(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_row_we(cfg_row_we), .cfg_row_addr(cfg_row_addr), .cfg_row_data(cfg_row_data),
    .cfg_tt_we(cfg_tt_we), .cfg_tt_addr(cfg_tt_addr), .cfg_tt_bit(cfg_tt_bit),
    .cfg_lock(cfg_lock), .cfg_unlock(cfg_unlock),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .running(running)
`ifdef AUTOSYM_CNT_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int a, input logic [7:0] d);
    cfg_row_we = 1'b1; cfg_row_addr = 2'(a); cfg_row_data = d;
    step();
    cfg_row_we = 1'b0;
  endtask

  task automatic wr_tt(input logic [15:0] t);
    for (int i = 0; i < 16; i++) begin
      cfg_tt_we = 1'b1; cfg_tt_addr = 4'(i); cfg_tt_bit = t[i];
      step();
    end
    cfg_tt_we = 1'b0;
  endtask

  task automatic lock;
    cfg_lock = 1'b1; step(); cfg_lock = 1'b0;
  endtask

  task automatic unlock_drain;
    cfg_unlock = 1'b1; step(); cfg_unlock = 1'b0;
    step(); step();
  endtask

  task automatic send1(input logic [7:0] v);
    in_valid = 1'b1; x = v; step(); in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    logic [7:0] bp_x[4];
    vt[0] = '{8'h01, 1'b1}; vt[1] = '{8'h05, 1'b0}; vt[2] = '{8'h00, 1'b1};
    vt[3] = '{8'h0F, 1'b1}; vt[4] = '{8'h1A, 1'b1}; vt[5] = '{8'hF6, 1'b1};
    vt[6] = '{8'h39, 1'b0}; vt[7] = '{8'h2C, 1'b0}; vt[8] = '{8'h88, 1'b1};
    vt[9] = '{8'h43, 1'b0};
    bp_x[0] = 8'h07; bp_x[1] = 8'h03; bp_x[2] = 8'hFF; bp_x[3] = 8'hFF;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_y", 32'(y), 0);
    // identity projection: z = x[3:0], TT = A5C3
    for (int i = 0; i < 4; i++) wr_row(i, 8'(1 << i));
    wr_tt(16'hA5C3);
    lock();
    chk("lock_running", 32'(running), 1);
    for (int i = 0; i < 10; i++) begin
      send1(vt[i].x);
      chk($sformatf("id_lat1_%0d", i), 32'(out_valid), 0);
      step();
      chk($sformatf("id_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("id_y_%0d", i), 32'(y), 32'(vt[i].y));
    end
    step();
    // parity: ROW0 = FF, TT[1] = 1
    unlock_drain();
    chk("unlock_running", 32'(running), 0);
    wr_row(0, 8'hFF); wr_row(1, 8'h00); wr_row(2, 8'h00); wr_row(3, 8'h00);
    wr_tt(16'h0002);
    lock();
    in_valid = 1'b1; x = 8'h07; step();
    x = 8'h03; step();
    chk("par_v0", 32'(out_valid), 1); chk("par_y0", 32'(y), 1);
    x = 8'hFF; step();
    chk("par_v1", 32'(out_valid), 1); chk("par_y1", 32'(y), 0);
    in_valid = 1'b0; step();
    chk("par_v2", 32'(out_valid), 1); chk("par_y2", 32'(y), 0);
    step();
    chk("par_empty", 32'(out_valid), 0);
    // backpressure: only two slots
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = bp_x[i];
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_hold_v", 32'(out_valid), 1);
    chk("bp_hold_y", 32'(y), 1);
    out_ready = 1'b1;
    step();
    chk("bp_v1", 32'(out_valid), 1); chk("bp_y1", 32'(y), 0);
    step();
    chk("bp_empty", 32'(out_valid), 0);
    // unlock with two results in flight
    out_ready = 1'b0;
    send1(8'h07); send1(8'h03);
    cfg_unlock = 1'b1; step(); cfg_unlock = 1'b0;
    #1;
    chk("drain_in_ready", 32'(in_ready), 0);
    chk("drain_running", 32'(running), 0);
    cfg_tt_we = 1'b1; cfg_tt_addr = 4'd0; cfg_tt_bit = 1'b1; step(); cfg_tt_we = 1'b0;
    chk("drain_v0", 32'(out_valid), 1); chk("drain_y0", 32'(y), 1);
    out_ready = 1'b1;
    step();
    chk("drain_v1", 32'(out_valid), 1); chk("drain_y1", 32'(y), 0);
    step();
    chk("drain_empty", 32'(out_valid), 0);
    step();
    lock();
    chk("relock_running", 32'(running), 1);
    send1(8'h03); step();
    chk("drain_wr_ignored", 32'(y), 0);
    // reset with a result pending
    send1(8'h07);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_running", 32'(running), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    step();
    chk("mid_rst_valid2", 32'(out_valid), 0);
    lock();
    send1(8'h07); step();
    chk("rst_tt_v", 32'(out_valid), 1); chk("rst_tt_y", 32'(y), 0);
    step();
    // write and lock in the same cycle
    unlock_drain();
    cfg_tt_we = 1'b1; cfg_tt_addr = 4'd0; cfg_tt_bit = 1'b1; cfg_lock = 1'b1;
    step();
    cfg_tt_we = 1'b0; cfg_lock = 1'b0;
    chk("wrlock_running", 32'(running), 1);
    send1(8'h5A); step();
    chk("wrlock_y", 32'(y), 1);
    step();
`ifdef AUTOSYM_CNT_EN
    chk("cnt_one", 32'(ones_cnt), 1);
    in_valid = 1'b1; x = 8'h00;
    for (int i = 0; i < 65540; i++) step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("cnt_sat", 32'(ones_cnt), 32'hFFFF);
    unlock_drain();
    lock();
    chk("cnt_clear", 32'(ones_cnt), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/autosym_eval.md
AUTOSYM_EVAL -- requirements
Module: autosym_eval

Interface
REQ-001 The block SHALL have parameter N_IN, default 8, giving the input vector width (2..32).
REQ-002 The block SHALL have parameter K, default 4, giving the restriction-space width (1..8, K <= N_IN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port cfg_row_we, input, 1 bit: write projection row cfg_row_addr.
REQ-006 The block SHALL have port cfg_row_addr, input, clog2(K) bits: projection row index.
REQ-007 The block SHALL have port cfg_row_data, input, N_IN bits: projection row mask.
REQ-008 The block SHALL have port cfg_tt_we, input, 1 bit: write restriction truth-table bit.
REQ-009 The block SHALL have port cfg_tt_addr, input, K bits: truth-table index.
REQ-010 The block SHALL have port cfg_tt_bit, input, 1 bit: truth-table value.
REQ-011 The block SHALL have port cfg_lock, input, 1 bit: single-cycle pulse requesting CFG->RUN.
REQ-012 The block SHALL have port cfg_unlock, input, 1 bit: single-cycle pulse requesting RUN->CFG.
REQ-013 The block SHALL have port in_valid, input, 1 bit: x is valid.
REQ-014 The block SHALL have port in_ready, output, 1 bit: the block accepts x this cycle.
REQ-015 The block SHALL have port x, input, N_IN bits: input vector.
REQ-016 The block SHALL have port out_valid, output, 1 bit: y is valid.
REQ-017 The block SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-018 The block SHALL have port y, output, 1 bit: function value f(x).
REQ-019 The block SHALL have port running, output, 1 bit: high in state RUN.

Function
REQ-020 The block SHALL compute f(x) = TT[z], with z[i] = XOR-reduce(x AND ROW[i]) for i = 0..K-1.
REQ-021 The block SHALL implement FSM states CFG, RUN and DRAIN.
REQ-022 CFG SHALL move to RUN on cfg_lock; RUN SHALL move to DRAIN on cfg_unlock; DRAIN SHALL move to CFG once both pipeline stages are empty.
REQ-023 In RUN, cfg_lock SHALL be ignored; in CFG and DRAIN, cfg_unlock SHALL be ignored.
REQ-024 Row and truth-table writes SHALL take effect only in CFG; writes in RUN or DRAIN SHALL be discarded.
REQ-025 A write and cfg_lock in the same cycle SHALL commit the write and then enter RUN.
REQ-026 in_ready SHALL be 0 in CFG and DRAIN.
REQ-027 In RUN, in_ready SHALL be 1 when stage 1 is empty or stage 1 advances in the same cycle.
REQ-028 Stage 1 SHALL register z and its valid bit; stage 2 SHALL register y and drive out_valid.
REQ-029 Latency SHALL be 2 cycles from an accepted x to out_valid with out_ready held high.
REQ-030 Throughput SHALL be one result per cycle.
REQ-031 Stage 2 SHALL advance when it is empty or out_ready=1.
REQ-032 Stage 1 SHALL advance into stage 2 whenever stage 2 advances.
REQ-033 With out_ready=0, the pipeline SHALL hold 2 results without loss or duplication.
REQ-034 While out_valid=1 and out_ready=0, y SHALL be stable.
REQ-035 In DRAIN, in-flight results SHALL be delivered using the configuration captured before cfg_unlock.

Reset
REQ-036 rst SHALL force state=CFG, all ROW=0, all TT=0, both stage-valid bits=0, y=0, out_valid=0, in_ready=0 and running=0 on the next clk edge.
REQ-037 rst mid-operation SHALL discard in-flight results without asserting out_valid.
REQ-038 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-039 Macro AUTOSYM_CNT_EN, when defined, SHALL add output ones_cnt (16 bits) counting delivered results (out_valid and out_ready) with y=1.
REQ-040 ones_cnt SHALL saturate at 16'hFFFF, clear on rst, and clear on the CFG->RUN transition.
REQ-041 Without AUTOSYM_CNT_EN, the ones_cnt port and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-042 Identity load: N_IN=8, K=4, ROW[i]=1<<i, TT=16'hA5C3, lock, x=8'h01, out_ready=1 -> out_valid 2 cycles later with y=1; x=8'h05 -> y=0.
REQ-043 Parity: ROW[0]=8'hFF, other rows 0, TT=16'h0002, stream 8'h07, 8'h03, 8'hFF on consecutive cycles -> y=1, 0, 0 on consecutive cycles.
REQ-044 Backpressure: out_ready=0, in_valid=1 for 4 cycles -> exactly 2 accepted and in_ready=0 afterwards; out_ready=1 -> both delivered in order.
REQ-045 Unlock while full: cfg_unlock with 2 results in flight -> in_ready=0, both delivered with old config, then state CFG and running=0; a TT write issued during DRAIN has no effect.
REQ-046 Reset mid-stream: assert rst with a result pending -> out_valid=0 next cycle, running=0, a re-lock with TT=0 yields y=0.
REQ-047 With AUTOSYM_CNT_EN: 70000 delivered y=1 results -> ones_cnt=16'hFFFF; lock after unlock -> ones_cnt=0.
